// File: rtl/regfile_arbiter_if.sv
// Bundle of requester handshakes, responses and regfile pins for regfile_arbiter.
// slave = arbiter side, master = requesters plus the regfile data return.
interface regfile_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_waddr;
  logic [DATA_W-1:0] req0_wdata;
  logic [ADDR_W-1:0] req0_raddr1;
  logic [ADDR_W-1:0] req0_raddr2;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_waddr;
  logic [DATA_W-1:0] req1_wdata;
  logic [ADDR_W-1:0] req1_raddr1;
  logic [ADDR_W-1:0] req1_raddr2;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata1;
  logic [DATA_W-1:0] rsp0_rdata2;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata1;
  logic [DATA_W-1:0] rsp1_rdata2;

  logic              rf_rst;
  logic              rf_EN;
  logic              rf_RD;
  logic              rf_WR;
  logic [ADDR_W-1:0] rf_si1;
  logic [DATA_W-1:0] rf_I1;
  logic [ADDR_W-1:0] rf_so1;
  logic [ADDR_W-1:0] rf_so2;
  logic [DATA_W-1:0] rf_O1;
  logic [DATA_W-1:0] rf_O2;

  modport master (
    output req0_valid, req0_wr, req0_waddr, req0_wdata, req0_raddr1, req0_raddr2,
    output req1_valid, req1_wr, req1_waddr, req1_wdata, req1_raddr1, req1_raddr2,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata1, rsp0_rdata2,
    input  rsp1_valid, rsp1_rdata1, rsp1_rdata2,
    input  rf_rst, rf_EN, rf_RD, rf_WR, rf_si1, rf_I1, rf_so1, rf_so2,
    output rf_O1, rf_O2
  );

  modport slave (
    input  req0_valid, req0_wr, req0_waddr, req0_wdata, req0_raddr1, req0_raddr2,
    input  req1_valid, req1_wr, req1_waddr, req1_wdata, req1_raddr1, req1_raddr2,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata1, rsp0_rdata2,
    output rsp1_valid, rsp1_rdata1, rsp1_rdata2,
    output rf_rst, rf_EN, rf_RD, rf_WR, rf_si1, rf_I1, rf_so1, rf_so2,
    input  rf_O1, rf_O2
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester sequencer for the 16x32 2R1W regfile; one command in flight at a time.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise req0 has fixed priority.
module regfile_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_arbiter_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]        state;
  logic              rst_hold;
  logic              rf_rst_q;
  logic              grant;
  logic              idle_ok;
  logic              accept;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] sel_raddr1;
  logic [ADDR_W-1:0] sel_raddr2;

  logic              lat_wr;
  logic              lat_owner;
  logic [ADDR_W-1:0] lat_waddr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] lat_raddr1;
  logic [ADDR_W-1:0] lat_raddr2;

  logic [DATA_W-1:0] r0_d1, r0_d2, r1_d1, r1_d2;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
  end
`else
  always_comb grant = bus.req1_valid && !bus.req0_valid;
`endif

  assign idle_ok        = (state == IDLE) && !rf_rst_q;
  assign bus.req0_ready = idle_ok && !grant;
  assign bus.req1_ready = idle_ok && grant;
  assign accept         = (bus.req0_valid && bus.req0_ready) ||
                          (bus.req1_valid && bus.req1_ready);

  always_comb begin
    sel_wr     = bus.req0_wr;
    sel_waddr  = bus.req0_waddr;
    sel_wdata  = bus.req0_wdata;
    sel_raddr1 = bus.req0_raddr1;
    sel_raddr2 = bus.req0_raddr2;
    if (grant) begin
      sel_wr     = bus.req1_wr;
      sel_waddr  = bus.req1_waddr;
      sel_wdata  = bus.req1_wdata;
      sel_raddr1 = bus.req1_raddr1;
      sel_raddr2 = bus.req1_raddr2;
    end
  end

  // rf_rst is held through one extra cycle after rst is first sampled high
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rst_hold   <= 1'b1;
      rf_rst_q   <= 1'b1;
      lat_wr     <= 1'b0;
      lat_owner  <= 1'b0;
      lat_waddr  <= '0;
      lat_wdata  <= '0;
      lat_raddr1 <= '0;
      lat_raddr2 <= '0;
      r0_d1      <= '0;
      r0_d2      <= '0;
      r1_d1      <= '0;
      r1_d2      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      rst_hold <= 1'b0;
      rf_rst_q <= rst_hold;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_wr     <= sel_wr;
            lat_owner  <= grant;
            lat_waddr  <= sel_waddr;
            lat_wdata  <= sel_wdata;
            lat_raddr1 <= sel_raddr1;
            lat_raddr2 <= sel_raddr2;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant;
`endif
            state      <= sel_wr ? WRITE : READ;
          end
        end
        WRITE: state <= RESP;
        READ:  state <= CAPT;
        CAPT: begin
          if (lat_owner) begin
            r1_d1 <= bus.rf_O1;
            r1_d2 <= bus.rf_O2;
          end else begin
            r0_d1 <= bus.rf_O1;
            r0_d2 <= bus.rf_O2;
          end
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_rst      = rf_rst_q;
  assign bus.rf_EN       = (state == WRITE) || (state == READ) || (state == CAPT);
  assign bus.rf_WR       = (state == WRITE);
  assign bus.rf_RD       = (state == READ);
  assign bus.rf_si1      = lat_waddr;
  assign bus.rf_I1       = lat_wdata;
  assign bus.rf_so1      = lat_raddr1;
  assign bus.rf_so2      = lat_raddr2;

  assign bus.rsp0_valid  = (state == RESP) && !lat_owner;
  assign bus.rsp1_valid  = (state == RESP) && lat_owner;
  assign bus.rsp0_rdata1 = r0_d1;
  assign bus.rsp0_rdata2 = r0_d2;
  assign bus.rsp1_rdata1 = r1_d1;
  assign bus.rsp1_rdata2 = r1_d2;

endmodule
